data_memory_lsu: RTL
====================

Name: data_memory_lsu

Overview:
- Parametrised successor to the team's word data memory.
- Adds byte, halfword and word loads and stores with sign or zero extension, and a req/ready request handshake.
- Read data is registered, with a one-cycle response.
- Flags out-of-window, misaligned and reserved-size accesses as errors.
- Sits between the core's load/store stage and the data RAM, and decodes its own address window.

Parameters:
- BASE_ADDR, 32'h8000_0000, first byte address of the memory window.
- DEPTH, 256, number of 32-bit words; power of two, 4..65536.
- AW, $clog2(DEPTH), word-index width (derived; not for override).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous active-high reset.
- req_i  in  1  request valid.
- ready_o  out  1  block can accept a request this cycle.
- we_i  in  1  1 = store, 0 = load.
- size_i  in  2  00 byte, 01 half, 10 word, 11 reserved.
- uns_i  in  1  load only: 1 = zero-extend, 0 = sign-extend.
- addr_i  in  32  byte address.
- wdata_i  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- rvalid_o  out  1  response pulse, one per accepted request.
- rdata_o  out  32  load result, extended to 32 bits; 0 for stores and errors.
- err_o  out  1  error flag, valid only while rvalid_o = 1.

Behaviour:
- Reset, synchronous, active-high:
  - rvalid_o = 0, rdata_o = 0, err_o = 0, FSM = IDLE.
  - ready_o = 0 while rst = 1, and 1 in the first cycle after rst falls.
  - RAM contents are not cleared.
- Acceptance: a request is accepted on the edge where req_i and ready_o are both 1.
- Timing:
  - A request accepted at edge N gives rvalid_o = 1 for exactly one cycle after edge N+1.
  - Back-to-back requests are allowed; ready_o stays 1 in IDLE.
- Window hit: all bytes of the access satisfy BASE_ADDR <= byte address <= BASE_ADDR + 4*DEPTH - 1.
  - The end address is computed in 33 bits, so wrap past 32'hFFFF_FFFF is a miss.
- Word index = (addr_i - BASE_ADDR) >> 2, taken modulo DEPTH; lane = addr_i[1:0].
- Alignment rules:
  - Byte is always aligned.
  - Half needs addr[0] = 0.
  - Word needs addr[1:0] = 00.
- Error cases:
  - Out-of-window, size 11, or misaligned (macro absent) → err_o = 1 and rdata_o = 0.
  - An error store writes no byte.
- Store lane placement:
  - Byte: wdata_i[7:0] goes to lane addr[1:0].
  - Half: wdata_i[15:0] goes to lanes {addr[1], 0} and {addr[1], 1}.
  - Word: all four lanes.
  - Other lanes are untouched.
  - A store responds with rvalid_o = 1, err_o = 0, rdata_o = 0.
- Load extraction: the selected lanes are extended per uns_i; the upper bits are all copies of the MSB, or 0 when uns_i = 1.
- Read-after-write: a load accepted at edge N+1 to a location stored at edge N returns the new data.
- FSM: IDLE, SPLIT. SPLIT exists only when DMEM_MISALIGN_EN is defined; without the macro the FSM stays in IDLE.
- req_i in the same cycle as rst is ignored.

Optional Feature:
- Macro: DMEM_MISALIGN_EN.
- Without the macro: misaligned half/word accesses respond err_o = 1, write nothing, and ready_o stays 1.
- With the macro, a misaligned access that hits the window runs as two beats:
  - Beat 1, on the accept edge N: accesses the lower word's lanes addr[1:0]..3.
  - FSM goes IDLE → SPLIT and ready_o = 0 for one cycle.
  - Beat 2, on edge N+1: accesses word index+1, lanes 0..(remaining bytes - 1).
  - FSM returns to IDLE; rvalid_o pulses after edge N+2.
  - Load result is assembled little-endian, then extended.
  - If the word index+1 overflows DEPTH, the access is out-of-window: err_o = 1, nothing written, no SPLIT entered.
  - rst while in SPLIT: second beat abandoned, no rvalid_o; bytes from beat 1 of a store remain written.

Test Plan:
- Reset then idle: rst = 1 for 2 cycles → rvalid_o = 0, rdata_o = 0, err_o = 0, ready_o = 0; ready_o = 1 on the first cycle after release.
- Byte/half/word store and load:
  - Store word 32'h8000_0010 ← 32'hDEAD_BEEF.
  - Byte load at 32'h8000_0013, signed → 32'hFFFF_FFDE; unsigned → 32'h0000_00DE.
  - Signed half load at 32'h8000_0010 → 32'hFFFF_BEEF.
  - Byte store 8'h12 to 32'h8000_0011, then word load → 32'hDEAD_12EF.
- Back-to-back read-after-write: store 32'h0000_00A5 to 32'h8000_0020 at edge N, load word at N+1 → rvalid_o after N+2 with rdata_o = 32'h0000_00A5; rvalid_o high on two consecutive cycles.
- Window boundary:
  - Word load at 32'h8000_03FC → err_o = 0.
  - Word load at 32'h8000_0400 → err_o = 1, rdata_o = 0.
  - Word store at 32'h7FFF_FFFC → err_o = 1, RAM unchanged.
  - size_i = 11 → err_o = 1.
- Misaligned access, macro absent: half load at 32'h8000_0001 → err_o = 1; half store there → RAM unchanged.
- Misaligned split, macro present:
  - Store word 32'h1122_3344 at 32'h8000_0006; ready_o = 0 for one cycle; rvalid_o after N+2.
  - Word loads at 32'h8000_0004 and 32'h8000_0008 then show bytes 0x44 and 0x33 in lanes 2..3 and bytes 0x22 and 0x11 in lanes 0..1 respectively.
  - Word access at 32'h8000_03FE → err_o = 1 with no SPLIT.
  - rst asserted during SPLIT → no rvalid_o.

Source files
------------

// File: rtl/data_memory_lsu_if.sv
// data_memory_lsu_if: request/response bus between the load/store stage and data_memory_lsu.
interface data_memory_lsu_if;
   logic        req_i;
   logic        ready_o;
   logic        we_i;
   logic [1:0]  size_i;
   logic        uns_i;
   logic [31:0] addr_i;
   logic [31:0] wdata_i;
   logic        rvalid_o;
   logic [31:0] rdata_o;
   logic        err_o;
   modport master (output req_i, we_i, size_i, uns_i, addr_i, wdata_i, input ready_o, rvalid_o, rdata_o, err_o);
   modport slave (input req_i, we_i, size_i, uns_i, addr_i, wdata_i, output ready_o, rvalid_o, rdata_o, err_o);
endinterface

// File: rtl/data_memory_lsu.sv
// data_memory_lsu: windowed byte/half/word data RAM with req/ready handshake and registered response.
// DMEM_MISALIGN_EN enables two-beat misaligned accesses; otherwise they respond with an error.
module data_memory_lsu #(
   parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
   parameter int DEPTH = 256,
   localparam int AW = $clog2(DEPTH)
) (
   input logic clk,
   input logic rst,
   data_memory_lsu_if.slave bus
);
   typedef enum logic {IDLE, SPLIT} state_t;
   state_t state, nxt;
   logic [31:0] mem [DEPTH];
   logic [2:0] nb;
   logic [32:0] last, limit;
   logic hit, mis, ok, go_split, acc, ready;
   logic [AW-1:0] idx, p_idx;
   logic [3:0] m4, p_m;
   logic [7:0] wide_m;
   logic [31:0] wd, p_d, s_lo, s_hi, sel, ext;
   logic [63:0] wide_d;
   logic s_v, s_we, s_err, s_uns, p_we;
   logic [1:0] s_size, s_lane;
   assign nb = bus.size_i == 2'd0 ? 3'd1 : bus.size_i == 2'd1 ? 3'd2 : 3'd4;
   assign last = {1'b0, bus.addr_i} + 33'(nb) - 33'd1;
   assign limit = {1'b0, BASE_ADDR} + 33'(4 * DEPTH) - 33'd1;
   assign hit = bus.addr_i >= BASE_ADDR && last <= limit;
   assign mis = (bus.size_i == 2'd1 && bus.addr_i[0]) || (bus.size_i == 2'd2 && bus.addr_i[1:0] != 2'd0);
`ifdef DMEM_MISALIGN_EN
   assign ok = hit && bus.size_i != 2'd3;
   assign go_split = ok && mis;
`else
   assign ok = hit && bus.size_i != 2'd3 && !mis;
   assign go_split = 1'b0;
`endif
   assign idx = AW'((bus.addr_i[AW+1:0] - BASE_ADDR[AW+1:0]) >> 2);
   assign m4 = bus.size_i == 2'd0 ? 4'h1 : bus.size_i == 2'd1 ? 4'h3 : 4'hF;
   assign wd = bus.size_i == 2'd0 ? {24'd0, bus.wdata_i[7:0]} : bus.size_i == 2'd1 ? {16'd0, bus.wdata_i[15:0]} : bus.wdata_i;
   // lower nibble/word is beat 1, upper spills into the next word for split accesses
   assign wide_m = {4'd0, m4} << bus.addr_i[1:0];
   assign wide_d = {32'd0, wd} << {bus.addr_i[1:0], 3'b000};
   assign acc = bus.req_i && ready;
   assign bus.ready_o = ready;
   always_comb begin
      ready = !rst && state == IDLE;
      nxt = state == SPLIT ? IDLE : acc && go_split ? SPLIT : IDLE;
   end
   always_ff @(posedge clk) state <= rst ? IDLE : nxt;
   always_ff @(posedge clk)
      for (int b = 0; b < 4; b++) begin
         if (acc && bus.we_i && ok && wide_m[b]) mem[idx][8*b+:8] <= wide_d[8*b+:8];
         if (!rst && state == SPLIT && p_we && p_m[b]) mem[p_idx][8*b+:8] <= p_d[8*b+:8];
      end
   always_comb begin
      sel = 32'({s_hi, s_lo} >> {s_lane, 3'b000});
      ext = s_size == 2'd0 ? {{24{~s_uns & sel[7]}}, sel[7:0]} :
            s_size == 2'd1 ? {{16{~s_uns & sel[15]}}, sel[15:0]} : sel;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         s_v <= 1'b0;
         bus.rvalid_o <= 1'b0;
         bus.rdata_o <= 32'd0;
         bus.err_o <= 1'b0;
      end else begin
         bus.rvalid_o <= s_v;
         bus.err_o <= s_v && s_err;
         bus.rdata_o <= s_v && !s_we && !s_err ? ext : 32'd0;
         s_v <= (acc && !go_split) || state == SPLIT;
         if (acc) begin
            s_we <= bus.we_i;
            s_err <= !ok;
            s_size <= bus.size_i;
            s_uns <= bus.uns_i;
            s_lane <= bus.addr_i[1:0];
            s_lo <= mem[idx];
            p_idx <= idx + 1'b1;
            p_we <= bus.we_i;
            p_d <= wide_d[63:32];
            p_m <= wide_m[7:4];
         end
         if (state == SPLIT) s_hi <= mem[p_idx];
      end
   end
endmodule
